fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Fetch-stage hazard controller. It decides whether the fetch stage runs
//   normally, holds (stall), squashes the fetched instruction (issue_nop),
//   or redirects to a branch target (pc_load/jmp_pc). It also keeps two
//   saturating performance counters.
//
// Parameters
//   FLUSH_CYCLES  NOP slots issued after a taken branch (1..7)
//   CNT_W         width of the performance counters
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   load_use       in   load-use hazard detected in decode
//   branch_taken   in   taken branch/jump resolved in execute
//   branch_target  in   redirect target, valid with branch_taken
//   halt_req       in   request to freeze fetch (level)
//   resume         in   leave HALT (level)
//   stall          out  hold fetch PC / replay last instruction
//   issue_nop      out  replace fetched instruction with a NOP
//   pc_load        out  one-cycle redirect pulse
//   jmp_pc         out  redirect target, zero when pc_load is low
//   halted         out  high while in HALT
//   stall_cnt      out  saturating count of stall cycles
//   flush_cnt      out  saturating count of pc_load pulses
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic             stall,
    output logic             issue_nop,
    output logic             pc_load,
    output logic [31:0]      jmp_pc,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [1:0]       state_reg,        state_next;
    logic [2:0]       nop_ctr_reg,      nop_ctr_next;
    logic             halt_pending_reg, halt_pending_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic             stall_c;
    logic             issue_nop_c;
    logic             pc_load_c;
    logic [31:0]      jmp_pc_c;
    logic             halted_c;

    // Next-state and output decode. Every output is forced low while reset
    // is high so downstream stages see a quiet fetch during reset.
    always_comb begin
        state_next        = state_reg;
        nop_ctr_next      = nop_ctr_reg;
        halt_pending_next = halt_pending_reg;
        stall_c           = 1'b0;
        issue_nop_c       = 1'b0;
        pc_load_c         = 1'b0;
        jmp_pc_c          = 32'h0;
        halted_c          = 1'b0;

        if (!reset) begin
            case (state_reg)
                ST_RUN: begin
                    // Priority: branch > load-use > halt request.
                    if (branch_taken) begin
                        pc_load_c    = 1'b1;
                        jmp_pc_c     = branch_target;
                        state_next   = ST_FLUSH;
                        nop_ctr_next = FLUSH_LOAD;
                    end else if (load_use) begin
                        stall_c = 1'b1;
                    end else if (halt_req) begin
                        state_next = ST_HALT;
                    end
                end

                ST_FLUSH: begin
                    // load_use is irrelevant here: the slot is already a NOP.
                    issue_nop_c = 1'b1;
                    if (halt_req) begin
                        halt_pending_next = 1'b1;
                    end
                    if (branch_taken) begin
                        // A younger taken branch restarts the flush window.
                        pc_load_c    = 1'b1;
                        jmp_pc_c     = branch_target;
                        nop_ctr_next = FLUSH_LOAD;
                    end else if (nop_ctr_reg == 3'd1) begin
                        // A halt request arriving on the last NOP slot still
                        // counts, so look at the incoming level as well.
                        nop_ctr_next      = 3'd0;
                        halt_pending_next = 1'b0;
                        state_next = (halt_pending_reg || halt_req) ? ST_HALT : ST_RUN;
                    end else begin
                        nop_ctr_next = nop_ctr_reg - 3'd1;
                    end
                end

                ST_HALT: begin
                    stall_c     = 1'b1;
                    issue_nop_c = 1'b1;
                    halted_c    = 1'b1;
                    // resume beats a simultaneous halt_req.
                    if (resume) begin
                        state_next = ST_RUN;
                    end
                end

                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_RUN;
            nop_ctr_reg      <= 3'd0;
            halt_pending_reg <= 1'b0;
            stall_cnt_reg    <= '0;
            flush_cnt_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            nop_ctr_reg      <= nop_ctr_next;
            halt_pending_reg <= halt_pending_next;
            if (stall_c && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (pc_load_c && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stall     = stall_c;
    assign issue_nop = issue_nop_c;
    assign pc_load   = pc_load_c;
    assign jmp_pc    = jmp_pc_c;
    assign halted    = halted_c;
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl (FLUSH_CYCLES=2, CNT_W=16). Each step
//   drives the inputs just after a rising edge, pushes the expected outputs
//   for that cycle into a scoreboard queue, and compares them at the
//   following falling edge. Counter expectations reflect events of earlier
//   cycles, since the counters are registered.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_use;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_req;
    logic        resume;
    logic        stall;
    logic        issue_nop;
    logic        pc_load;
    logic [31:0] jmp_pc;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    always #5 clk = ~clk;

    fetch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .resume       (resume),
        .stall        (stall),
        .issue_nop    (issue_nop),
        .pc_load      (pc_load),
        .jmp_pc       (jmp_pc),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    typedef struct packed {
        logic        stall;
        logic        nop;
        logic        pcl;
        logic [31:0] jmp;
        logic        halted;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   step_no     = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL step %0d %s observed=%h expected=%h", step_no, tag, obs, expv);
        end
    endtask

    // Drive one cycle, queue its expectation, then pop and compare.
    task automatic step(input bit rst, input bit lu, input bit bt,
                        input logic [31:0] tgt, input bit hr, input bit rs,
                        input bit e_stall, input bit e_nop, input bit e_pcl,
                        input logic [31:0] e_jmp, input bit e_halted,
                        input logic [15:0] e_sc, input logic [15:0] e_fc);
        exp_t e;
        reset         = rst;
        load_use      = lu;
        branch_taken  = bt;
        branch_target = tgt;
        halt_req      = hr;
        resume        = rs;
        q.push_back('{e_stall, e_nop, e_pcl, e_jmp, e_halted, e_sc, e_fc});
        @(negedge clk);
        step_no++;
        vectors++;
        assert (q.size() != 0)
        else begin
            miscompares++;
            $error("FAIL step %0d scoreboard_empty observed=0 expected=1", step_no);
        end
        e = q.pop_front();
        cmp("stall",     {31'h0, stall},     {31'h0, e.stall});
        cmp("issue_nop", {31'h0, issue_nop}, {31'h0, e.nop});
        cmp("pc_load",   {31'h0, pc_load},   {31'h0, e.pcl});
        cmp("jmp_pc",    jmp_pc,             e.jmp);
        cmp("halted",    {31'h0, halted},    {31'h0, e.halted});
        cmp("stall_cnt", {16'h0, stall_cnt}, {16'h0, e.sc});
        cmp("flush_cnt", {16'h0, flush_cnt}, {16'h0, e.fc});
        $display("step %0d: rst=%b lu=%b bt=%b hr=%b rs=%b -> stall=%b nop=%b pcl=%b jmp=%h halted=%b sc=%h fc=%h",
                 step_no, rst, lu, bt, hr, rs, stall, issue_nop, pc_load, jmp_pc, halted,
                 stall_cnt, flush_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Unchecked first reset cycle so registers hold known values.
        reset = 1'b1; load_use = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; halt_req = 1'b0; resume = 1'b0;
        @(posedge clk);
        #1;

        // Reset with busy inputs: outputs quiet, counters zero.
        step(1, 1, 1, 32'hDEAD_BEEF, 1, 1,  0, 0, 0, 32'h0, 0, 16'd0, 16'd0);
        step(0, 0, 0, 32'h0,         0, 0,  0, 0, 0, 32'h0, 0, 16'd0, 16'd0);

        // Taken branch to 0x40, two NOP cycles, back to RUN.
        step(0, 0, 1, 32'h0000_0040, 0, 0, 0, 0, 1, 32'h40, 0, 16'd0, 16'd0);
        step(0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 32'h0,  0, 16'd0, 16'd1);
        step(0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 32'h0,  0, 16'd0, 16'd1);
        step(0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,  0, 16'd0, 16'd1);

        // Load-use for three cycles.
        step(0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 0, 16'd0, 16'd1);
        step(0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 0, 16'd1, 16'd1);
        step(0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 0, 16'd2, 16'd1);
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 16'd3, 16'd1);

        // Branch + load-use together, branch again on first FLUSH cycle,
        // load-use during FLUSH ignored.
        step(0, 1, 1, 32'h0000_0100, 0, 0, 0, 0, 1, 32'h100, 0, 16'd3, 16'd1);
        step(0, 0, 1, 32'h0000_0200, 0, 0, 0, 1, 1, 32'h200, 0, 16'd3, 16'd2);
        step(0, 1, 0, 32'h0,         0, 0, 0, 1, 0, 32'h0,   0, 16'd3, 16'd3);
        step(0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 32'h0,   0, 16'd3, 16'd3);
        step(0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,   0, 16'd3, 16'd3);

        // halt_req on FLUSH cycle 1: full flush, then HALT; branch/load-use
        // ignored in HALT; resume beats halt_req.
        step(0, 0, 1, 32'h0000_0300, 0, 0, 0, 0, 1, 32'h300, 0, 16'd3, 16'd3);
        step(0, 0, 0, 32'h0,         1, 0, 0, 1, 0, 32'h0,   0, 16'd3, 16'd4);
        step(0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 32'h0,   0, 16'd3, 16'd4);
        step(0, 0, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,   1, 16'd3, 16'd4);
        step(0, 1, 1, 32'h0000_0400, 0, 0, 1, 1, 0, 32'h0,   1, 16'd4, 16'd4);
        step(0, 0, 0, 32'h0,         1, 1, 1, 1, 0, 32'h0,   1, 16'd5, 16'd4);
        step(0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,   0, 16'd6, 16'd4);

        // Halt directly from RUN; no stall in the requesting cycle.
        step(0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0, 16'd6, 16'd4);
        step(0, 0, 0, 32'h0, 0, 0, 1, 1, 0, 32'h0, 1, 16'd6, 16'd4);
        step(0, 0, 0, 32'h0, 0, 1, 1, 1, 0, 32'h0, 1, 16'd7, 16'd4);
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 16'd8, 16'd4);

        // load_use outranks halt_req in RUN.
        step(0, 1, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0, 0, 16'd8, 16'd4);
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 16'd9, 16'd4);

        // Reset on the first FLUSH cycle aborts the flush.
        step(0, 0, 1, 32'h0000_0040, 0, 0, 0, 0, 1, 32'h40, 0, 16'd9, 16'd4);
        step(1, 0, 1, 32'h0000_0080, 0, 0, 0, 0, 0, 32'h0,  0, 16'd9, 16'd5);
        step(0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,  0, 16'd0, 16'd0);
        step(0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,  0, 16'd0, 16'd0);

        // Reset while in HALT leaves no residual halt.
        step(0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);
        step(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 16'd0, 16'd0);

        // Saturation: 65534 stall cycles bring stall_cnt to 16'hFFFE.
        load_use = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        step(0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 0, 16'hFFFE, 16'd0);
        step(0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 0, 16'hFFFF, 16'd0);
        step(0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 0, 16'hFFFF, 16'd0);
        step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 16'hFFFF, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
